// File: rtl/uart_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_pkg: shared receive-path types, parity constants and prescale values.
// Revision: 1.0
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_sampler: oversampling counter and per-bit decision strobe.
// Build option UART_RX_MAJORITY_EN selects a 3-sample vote around mid-bit.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic                  active,
    input  logic                  start_det,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  bit_wrap,
    output logic                  sample_done,
    output logic                  sample_bit
);

    localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0] edge_cnt;
    logic [PRESCALE_W-1:0] half;

    assign half     = prescale >> 1;
    assign bit_wrap = active && (edge_cnt == prescale - CNT_ONE);

    // The first low cycle seen in IDLE is edge 0 of the start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= '0;
        end else if (!active) begin
            edge_cnt <= start_det ? CNT_ONE : '0;
        end else if (bit_wrap) begin
            edge_cnt <= '0;
        end else begin
            edge_cnt <= edge_cnt + CNT_ONE;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist <= '0;
        end else begin
            hist <= {hist[0], rx_in};
        end
    end

    assign sample_done = active && (edge_cnt == half + CNT_ONE);
    assign sample_bit  = majority3(hist[1], hist[0], rx_in);
`else
    assign sample_done = active && (edge_cnt == half);
    assign sample_bit  = rx_in;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_rx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_rx_frame: UART receiver - start/data/parity/stop framing and checks.
// Build option UART_RX_MAJORITY_EN enables 3-sample majority bit decisions.
// Revision: 1.0
// ----------------------------------------------------------------------------
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  par_en,
    input  logic                  par_type,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_ONE  = BIT_CNT_W'(1);

    rx_state_t             state;
    logic [PRESCALE_W-1:0] prescale_q;
    logic                  par_en_q;
    logic                  par_type_q;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_flag;

    logic active;
    logic start_det;
    logic bit_wrap;
    logic sample_done;
    logic sample_bit;
    logic par_expected;

    assign active       = (state != IDLE);
    assign start_det    = (state == IDLE) && !rx_in;
    assign par_expected = (par_type_q == PAR_ODD) ? ~^shift_reg : ^shift_reg;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .active      (active),
        .start_det   (start_det),
        .prescale    (prescale_q),
        .bit_wrap    (bit_wrap),
        .sample_done (sample_done),
        .sample_bit  (sample_bit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            prescale_q <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_flag   <= 1'b0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_in) begin
                        state      <= START;
                        prescale_q <= prescale;
                        par_en_q   <= par_en;
                        par_type_q <= par_type;
                        par_flag   <= 1'b0;
                        bit_cnt    <= '0;
                    end
                end
                START: begin
                    // A high mid-bit decision means the low level was a glitch.
                    if (sample_done && sample_bit) begin
                        state <= IDLE;
                    end else if (bit_wrap) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (sample_done) begin
                        shift_reg <= {sample_bit, shift_reg[DATA_WIDTH-1:1]};
                    end
                    if (bit_wrap) begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= par_en_q ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_ONE;
                        end
                    end
                end
                PARITY: begin
                    if (sample_done && (sample_bit != par_expected)) begin
                        par_flag <= 1'b1;
                    end
                    if (bit_wrap) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    // Leaving mid-stop-bit lets a back-to-back start bit through.
                    if (sample_done) begin
                        stp_err <= !sample_bit;
                        par_err <= par_flag;
                        if (sample_bit && !par_flag) begin
                            p_data     <= shift_reg;
                            data_valid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_uart_rx_frame: randomized frames against a behavioural frame model with
// a queue-based scoreboard popped by an independent output monitor.
// ----------------------------------------------------------------------------
module tb_uart_rx_frame;

    localparam int DW = 8;
    localparam int PW = 6;
`ifdef UART_RX_MAJORITY_EN
    localparam int LAT_ADJ = 0;
`else
    localparam int LAT_ADJ = 1;
`endif

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          rx_in    = 1'b1;
    logic [PW-1:0] prescale = 6'd8;
    logic          par_en   = 1'b0;
    logic          par_type = 1'b0;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;

    uart_rx_frame #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .prescale   (prescale),
        .par_en     (par_en),
        .par_type   (par_type),
        .p_data     (p_data),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          valid;
        bit          perr;
        bit          serr;
        logic [7:0]  pdata;
        int          due;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] model_pdata = 8'h00;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: a frame is good unless its parity bit disagrees with the
    // configured parity of the payload or its stop bit is 0.
    task automatic send_frame(input logic [7:0] d, input int p, input bit pe,
                              input bit pt, input bit bad_par, input bit stop,
                              input int glitch_bit, input bit expect_it);
        bit   bits[$];
        bit   pbit;
        int   ones;
        exp_t e;
        ones = $countones(d);
        pbit = (pt ? (ones % 2 == 0) : (ones % 2 == 1)) ^ bad_par;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back(pbit);
        bits.push_back(stop);
        prescale = PW'(p);
        par_en   = pe;
        par_type = pt;
        if (expect_it) begin
            e.perr  = pe && bad_par;
            e.serr  = !stop;
            e.valid = !e.perr && !e.serr;
            if (e.valid) model_pdata = d;
            e.pdata = model_pdata;
            e.due   = cyc + (9 + int'(pe)) * p + p / 2 + 2 - LAT_ADJ;
            sb.push_back(e);
        end
        foreach (bits[b]) begin
            for (int j = 0; j < p; j++) begin
                rx_in = (b == glitch_bit && j == p / 2) ? ~bits[b] : bits[b];
                @(posedge clk);
                #1;
            end
        end
        rx_in = 1'b1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst && (data_valid || par_err || stp_err)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse actual dv=%b pe=%b se=%b required no pulse (t=%0t)",
                         data_valid, par_err, stp_err, $time);
            end else begin
                e = sb.pop_front();
                check("data_valid", data_valid, e.valid);
                check("par_err", par_err, e.perr);
                check("stp_err", stp_err, e.serr);
                check("p_data", p_data, e.pdata);
                check("latency_cycle", cyc, e.due);
            end
        end
    end

    initial begin
        int p;
        int gap;
        bit stop;
        bit pe;

        rx_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_p_data", p_data, 0);
        check("reset_data_valid", data_valid, 0);
        check("reset_par_err", par_err, 0);
        check("reset_stp_err", stp_err, 0);
        rst = 1'b1;
        idle(5);

        send_frame(8'hA5, 8, 0, 0, 0, 1, -1, 1);
        idle(4);
        send_frame(8'h3C, 16, 1, 0, 0, 1, -1, 1);
        idle(4);
        send_frame(8'h3C, 16, 1, 0, 1, 1, -1, 1);
        idle(4);
        send_frame(8'h01, 8, 1, 1, 0, 0, -1, 1);
        idle(10);

        // Two-cycle low glitch must be rejected as a false start.
        prescale = 6'd16;
        rx_in    = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        idle(40);
        send_frame(8'h5A, 16, 0, 0, 0, 1, -1, 1);
        idle(3);

        send_frame(8'h11, 32, 0, 0, 0, 1, -1, 1);
        send_frame(8'hEE, 32, 0, 0, 0, 1, -1, 1);
        idle(3);

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h96, 16, 0, 0, 0, 1, 4, 1);
        idle(3);
`endif

        fork
            send_frame(8'hFF, 16, 0, 0, 0, 1, -1, 0);
            begin
                repeat (48) @(posedge clk);
                #3;
                rst = 1'b0;
                model_pdata = 8'h00;
                #1;
                check("abort_p_data", p_data, 0);
                check("abort_data_valid", data_valid, 0);
                repeat (3) @(posedge clk);
                #3;
                rst = 1'b1;
            end
        join
        idle(20);
        send_frame(8'h42, 8, 0, 0, 0, 1, -1, 1);
        idle(4);

        p = 8;
        stop = 1'b1;
        for (int k = 0; k < 20; k++) begin
            gap = stop ? int'($urandom_range(0, 3)) : p + 2;
            idle(gap);
            case ($urandom_range(0, 2))
                0:       p = 8;
                1:       p = 16;
                default: p = 32;
            endcase
            pe   = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 4) != 0);
            send_frame(8'($urandom), p, pe, 1'($urandom_range(0, 1)),
                       pe && ($urandom_range(0, 3) == 0), stop, -1, 1);
        end
        idle(p + 2);

        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
UART receiver, the receive-side counterpart of the TX serializer/parity path.
- Oversamples the serial line `rx_in` by a runtime prescale.
- Detects and validates the start bit, then deserializes DATA_WIDTH bits, LSB first.
- Checks the optional parity bit and the stop bit.
- Presents the parallel word with a one-cycle valid pulse, or a one-cycle error pulse.
- Sits between the pad synchronizer and the RX FIFO / register block.

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- PRESCALE_W, 6, width of the prescale input. Supported prescale values are 8, 16 and 32.

Ports:
- clk  input  1  system clock, PRESCALE × baud rate.
- rst  input  1  asynchronous active-low reset.
- rx_in  input  1  serial line, already synchronized. Idle level is 1.
- prescale  input  PRESCALE_W  oversampling ratio. Sampled at start detection.
- par_en  input  1  1 = frame carries a parity bit. Sampled at start detection.
- par_type  input  1  1 = odd parity, 0 = even parity. Sampled at start detection.
- p_data  output  DATA_WIDTH  received word. Holds its value until the next good frame.
- data_valid  output  1  one-cycle pulse for a frame with no errors.
- par_err  output  1  one-cycle pulse when the parity check fails.
- stp_err  output  1  one-cycle pulse when the sampled stop bit is 0.

Behaviour:
- Reset: async, active-low. Outputs reset to p_data=0, data_valid=0, par_err=0, stp_err=0. FSM goes to IDLE; all counters and the shift register clear. Reset mid-frame aborts the frame with no pulse.
- Counters:
  - edge_cnt runs 0..prescale-1 within each bit and wraps.
  - bit_cnt advances when edge_cnt wraps.
  - h = prescale/2.
- Sampling: the bit value is the majority of rx_in at edge_cnt = h-1, h and h+1. The decision is registered at edge_cnt = h+1. Example for prescale=8: samples at 3, 4, 5.
- States and transitions:
  - IDLE: rx_in==0 → START, edge_cnt=0. Latch prescale, par_en and par_type.
  - START: if the sampled bit = 1, it is a glitch → IDLE with no pulse. Otherwise, at the edge_cnt wrap → DATA.
  - DATA: shift the sampled bit in at the MSB of the shift register, so the first bit ends up as the LSB. After DATA_WIDTH bits, go to PARITY if par_en, else STOP.
  - PARITY: expected bit = par_type ? ~^shift : ^shift. A mismatch sets a sticky internal flag. Then → STOP.
  - STOP: decision at edge_cnt = h+1. The next cycle (latency 1):
    - If stop=0: pulse stp_err.
    - If the parity flag is set: pulse par_err.
    - If both fault, pulse both; data_valid stays 0.
    - If no error: load p_data from the shift register and pulse data_valid.
    - The FSM returns to IDLE at the same time, so a back-to-back start bit is accepted from mid-stop-bit onward.
- Latency: data_valid asserts (9 + par_en)×prescale + h + 2 cycles after the first low cycle of the start bit.
- A prescale value outside {8, 16, 32} gives undefined results and is not checked.
- rx_in toggling during IDLE with no low level produces no activity.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: 3-sample majority vote as described above.
- Undefined: single sample at edge_cnt = h. The decision is registered at h, so every downstream event moves 1 cycle earlier; the latency formula loses 1. The glitch filter uses the single sample.

Decomposition:
- Shared package uart_pkg holds:
  - the rx_state_t enum {IDLE, START, DATA, PARITY, STOP};
  - the PAR_EVEN=0 and PAR_ODD=1 constants;
  - the supported prescale constants.
- Natural sub-module: uart_rx_sampler. It holds edge_cnt, the sample shift, the majority vote and the `sample_done` strobe.
- The FSM, bit_cnt, shift register and checks stay in uart_rx_frame.

Test Plan:
- prescale=8, par_en=0, send 0xA5 → p_data=0xA5. data_valid pulses 1 cycle at start + 9×8 + 6 = 78 cycles. No error pulses.
- prescale=16, par_en=1, par_type=0 (even), send 0x3C with parity 0 → data_valid, p_data=0x3C. Resend with parity 1 → par_err pulse, no data_valid, p_data stays 0x3C.
- prescale=8, par_en=1, par_type=1 (odd), send 0x01 with stop=0 → stp_err pulse, par_err=0, data_valid=0.
- Glitch: rx_in low for 2 cycles then high, prescale=16 → FSM returns to IDLE, no pulses. Then a valid frame 0x5A is received correctly.
- Back-to-back frames 0x11 and 0xEE, prescale=32, no idle gap → two data_valid pulses with the correct data. Also a single-cycle rx_in glitch at sample h inside a data bit is rejected (majority variant only).
- Assert rst mid-DATA for frame 0xFF → outputs zero immediately and no pulse. The next frame 0x42 is received correctly.
